// File: rtl/uart_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared definitions for the two-requester UART transmit arbiter.
//   NUM_REQ  : number of requesters served by the arbiter.
//   DEF_TO_W : default width of the tx_done timeout counter.
//   state_t  : message sequencing states of uart_tx_arb.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_ctrl_pkg;

    localparam int NUM_REQ  = 2;
    localparam int DEF_TO_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND_HI = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_SEND_LO = 3'd4,
        ST_WAIT_LO = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin selector (purely combinational).
//   i_req    [NUM_REQ-1:0] : request vector {req1, req0}.
//   i_last                 : index of the most recent grantee.
//   o_winner               : index of the selected requester.
//   o_valid                : at least one request is active.
// A lone requester always wins; on a tie the requester that was not served
// last wins.
// -----------------------------------------------------------------------------
module rr_arb2
    import uart_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_last,
    output logic               o_winner,
    output logic               o_valid
);

    always_comb begin
        o_valid  = |i_req;
        o_winner = 1'b0;
        if (i_req == 2'b11) begin
            o_winner = ~i_last;
        end else begin
            o_winner = i_req[1];
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// Arbitrates two message requesters onto one byte-wide UART transmitter and
// sequences one or two bytes per message.
//   clk, rst_n          : clock, asynchronous active-low reset.
//   req0/1              : requester wants to send (held until its ack).
//   len0/1              : 1 = two bytes (hi then lo), 0 = lo byte only.
//   data0/1 [15:0]      : message payload.
//   ack0/1              : one-cycle pulse when the message finished/aborted.
//   trmt                : one-cycle start strobe to the transmitter.
//   tx_data [7:0]       : byte for the transmitter, stable until it completes.
//   tx_done             : transmitter done level (a rising edge = byte sent).
//   busy                : high whenever the FSM is not idle.
//   gnt                 : index of the current or most recent grantee.
//   err                 : one-cycle pulse when a byte timed out.
//   o_state             : current FSM state, for observation only.
//
// Handshake: a requester raises reqN with stable lenN/dataN and keeps it up
// until ackN pulses; the message is captured at grant, so anything the
// requester does to req/len/data after the grant is ignored, and the message
// always completes with an ack (unless reset intervenes).
// -----------------------------------------------------------------------------
module uart_tx_arb
    import uart_ctrl_pkg::*;
#(
    parameter int TO_W = DEF_TO_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        len0,
    input  logic [15:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic        len1,
    input  logic [15:0] data1,
    output logic        ack1,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic        gnt,
    output logic        err,
    output state_t      o_state
);

    state_t            r_state;
    logic [15:0]       r_data;
    logic              r_len;
    logic              r_gnt;
    logic              r_last;
    logic [7:0]        r_tx_data;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_tx_done_q;
    logic              r_done_rise;
    logic              r_err;

    state_t            w_next;
    logic              w_winner;
    logic              w_valid;
    logic [TO_W-1:0]   w_to_cnt_inc;
    logic              w_timeout;
    logic              w_to_err;
    logic              w_in_wait;
    logic [7:0]        w_tx_data_nxt;

    rr_arb2 u_rr_arb2 (
        .i_req    ({req1, req0}),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    assign w_in_wait    = (r_state == ST_WAIT_HI) || (r_state == ST_WAIT_LO);
    assign w_to_cnt_inc = r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
    // Fire on the cycle in which the counter would become all-ones, so the
    // abort lands exactly 2^TO_W-1 cycles after entering the WAIT state.
    assign w_timeout    = &w_to_cnt_inc;

    always_comb begin
        w_next        = r_state;
        w_to_err      = 1'b0;
        w_tx_data_nxt = r_tx_data;
        case (r_state)
            ST_IDLE:    if (w_valid) w_next = ST_LOAD;
            ST_LOAD:    w_next = r_len ? ST_SEND_HI : ST_SEND_LO;
            ST_SEND_HI: w_next = ST_WAIT_HI;
            ST_SEND_LO: w_next = ST_WAIT_LO;
            ST_WAIT_HI: begin
                // A real completion takes precedence over a simultaneous timeout.
                if (r_done_rise) begin
                    w_next = ST_SEND_LO;
                end else if (w_timeout) begin
                    w_next   = ST_DONE;
                    w_to_err = 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (r_done_rise) begin
                    w_next = ST_DONE;
                end else if (w_timeout) begin
                    w_next   = ST_DONE;
                    w_to_err = 1'b1;
                end
            end
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase

        // The byte register is loaded on entry to a SEND state and cleared on
        // return to IDLE, so it is stable for the whole byte transfer.
        case (w_next)
            ST_SEND_HI: w_tx_data_nxt = r_data[15:8];
            ST_SEND_LO: w_tx_data_nxt = r_data[7:0];
            ST_IDLE:    w_tx_data_nxt = 8'h00;
            default:    w_tx_data_nxt = r_tx_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= 16'h0000;
            r_len       <= 1'b0;
            r_gnt       <= 1'b0;
            r_last      <= 1'b1;
            r_tx_data   <= 8'h00;
            r_to_cnt    <= '0;
            r_tx_done_q <= 1'b0;
            r_done_rise <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_valid) begin
                r_data <= w_winner ? data1 : data0;
                r_len  <= w_winner ? len1  : len0;
                r_gnt  <= w_winner;
            end
            if (r_state == ST_DONE) begin
                r_last <= r_gnt;
            end
            r_tx_data <= w_tx_data_nxt;
            // Counter is held at zero outside WAIT, which clears it on entry.
            if (w_in_wait) begin
                r_to_cnt <= w_to_cnt_inc;
            end else begin
                r_to_cnt <= '0;
            end
            // Edge detect against the previous level; the registered pulse
            // means a level already high when a byte starts never counts.
            r_tx_done_q <= tx_done;
            r_done_rise <= tx_done & ~r_tx_done_q;
            r_err       <= w_to_err;
        end
    end

    assign trmt    = (r_state == ST_SEND_HI) || (r_state == ST_SEND_LO);
    assign ack0    = (r_state == ST_DONE) && !r_gnt;
    assign ack1    = (r_state == ST_DONE) &&  r_gnt;
    assign err     = r_err;
    assign busy    = (r_state != ST_IDLE);
    assign gnt     = r_gnt;
    assign tx_data = r_tx_data;
    assign o_state = r_state;

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter TO_W, default 20, width of the tx_done timeout counter; timeout fires at 2^TO_W-1 cycles.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0  input  1  requester 0 wants to send; held until ack0.
REQ-005 len0  input  1  requester 0 length: 1 = two bytes (hi then lo), 0 = one byte (lo only).
REQ-006 data0  input  16  requester 0 payload.
REQ-007 ack0  output  1  one-cycle pulse when requester 0's message has finished or been aborted.
REQ-008 req1, len1, data1, ack1: identical to REQ-004..REQ-007 for requester 1.
REQ-009 trmt  output  1  one-cycle pulse to the UART transmitter to start a byte.
REQ-010 tx_data  output  8  byte presented to the UART transmitter; stable from the trmt cycle until that byte completes.
REQ-011 tx_done  input  1  UART transmitter done level.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 gnt  output  1  index of the current or most recent grantee.
REQ-014 err  output  1  one-cycle pulse on a tx_done timeout.

Function
REQ-015 States SHALL be IDLE, LOAD, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, DONE.
REQ-016 IDLE with no req: remain in IDLE; outputs hold their reset values, except gnt, which holds.
REQ-017 IDLE with any req: grant using round-robin.
- If only one requester is active, it wins.
- If both are active, the requester other than the last grantee wins.
- After reset, requester 0 wins a tie.
REQ-018 On grant, the block SHALL latch data, len and index into internal registers, update gnt, and go to LOAD; later changes on req/data/len are ignored until DONE.
REQ-019 LOAD SHALL go to SEND_HI if the latched len=1, else to SEND_LO.
REQ-020 SEND_HI: trmt=1 for exactly one cycle, tx_data=data[15:8]; next state WAIT_HI.
REQ-021 SEND_LO: trmt=1 for exactly one cycle, tx_data=data[7:0]; next state WAIT_LO.
REQ-022 Byte completion SHALL be the rising edge of tx_done, detected against a registered copy; a tx_done level left high from an earlier byte SHALL NOT count.
REQ-023 WAIT_HI SHALL go to SEND_LO on completion; WAIT_LO SHALL go to DONE on completion.
REQ-024 DONE SHALL pulse the grantee's ack for one cycle, record the grantee as last grantee, and return to IDLE. A new grant is possible on the next cycle.
REQ-025 Latency: grant to first trmt = 2 cycles. Completion edge to the next trmt or ack = 2 cycles.
REQ-026 Timeout counter:
- clears on entry to WAIT_HI/WAIT_LO;
- increments each cycle spent in a WAIT state;
- on reaching all-ones, the block pulses err and goes to DONE (ack still pulses; the low byte is skipped).
REQ-027 If a requester drops req mid-message, the message SHALL complete and ack SHALL still pulse.
REQ-028 ack0 and ack1 SHALL never be high in the same cycle; trmt SHALL never be high on two consecutive cycles.

Reset
REQ-029 Asynchronous assertion of rst_n SHALL force:
- state = IDLE;
- trmt, ack0, ack1 and err = 0;
- tx_data = 8'h00, gnt = 0, busy = 0;
- last grantee = 1, so requester 0 has priority;
- timeout counter = 0, tx_done history = 0.
REQ-030 Reset mid-message SHALL abandon the message with no ack. Deassertion takes effect at the next clk edge.

Structure
REQ-031 Package uart_ctrl_pkg SHALL hold the state enum typedef, NUM_REQ=2, and the default TO_W.
REQ-032 Round-robin selection SHALL be a sub-module rr_arb2 (inputs: req[1:0], last; output: winner index, valid); the FSM and datapath stay in uart_tx_arb.

Verification
REQ-033 req0=1, len0=1, data0=16'hA55A. Required: trmt with tx_data=8'hA5, then after the tx_done rise trmt with 8'h5A, then after the second rise one ack0 pulse, 2 cycles after the edge.
REQ-034 req0=req1=1 after reset, both len=0, data0=16'h0011, data1=16'h0022. Required: 8'h11 sent and ack0 first, then 8'h22 and ack1; gnt goes 0 then 1.
REQ-035 Both requesters held continuously for 4 messages. Required: grants alternate 0,1,0,1; no ack overlap.
REQ-036 tx_done held high from before the grant. Required: no byte advance until tx_done goes low then high again.
REQ-037 TO_W=4 and tx_done stuck low. Required: err and ack pulse 15 cycles after entry to WAIT, state returns to IDLE, and no low byte is sent when len=1.
REQ-038 rst_n pulsed low during WAIT_HI. Required: all outputs at reset values immediately, no ack, and the next grant goes to requester 0.
